// File: rtl/gate_sweep_pkg.sv
// gate_sweep_pkg: shared types and sizes for the 4-input gate sweep checker.
package gate_sweep_pkg;
  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_e;
  localparam int N_INPUTS  = 4;
  localparam int N_VECTORS = 16;
  localparam int IDX_W     = 4;
  localparam int ERR_W     = 5;
endpackage

// File: rtl/gate_sweep_checker.sv
// gate_sweep_checker: sweeps all 16 vectors onto a 4-input gate and checks its truth table.
module gate_sweep_checker
  import gate_sweep_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                 i_CLK,
  input  logic                 i_RST_N,
  input  logic                 i_START,
  input  logic [N_VECTORS-1:0] i_EXPECTED,
  output logic                 o_A,
  output logic                 o_B,
  output logic                 o_C,
  output logic                 o_D,
  input  logic                 i_Y,
  output logic                 o_BUSY,
  output logic                 o_DONE,
  output logic                 o_PASS,
  output logic [N_VECTORS-1:0] o_TABLE,
  output logic [ERR_W-1:0]     o_ERR_COUNT,
  output logic [IDX_W-1:0]     o_FIRST_ERR_IDX
);
  state_e               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d, cnt_q, cnt_d, first_q, first_d;
  logic [N_VECTORS-1:0] exp_q, exp_d, tbl_q, tbl_d;
  logic [ERR_W-1:0]     err_q, err_d;
  logic                 pass_q, pass_d, miss;
  assign miss = i_Y != exp_q[idx_q];
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    first_d = first_q;
    exp_d   = exp_q;
    tbl_d   = tbl_q;
    err_d   = err_q;
    pass_d  = pass_q;
    case (state_q)
      SETTLE: begin
        state_d = cnt_q == IDX_W'(SETTLE_CYCLES - 1) ? SAMPLE : SETTLE;
        cnt_d   = cnt_q == IDX_W'(SETTLE_CYCLES - 1) ? cnt_q : cnt_q + IDX_W'(1);
      end
      SAMPLE: begin
        tbl_d[idx_q] = i_Y;
        err_d        = miss ? err_q + ERR_W'(1) : err_q;
        first_d      = (miss && err_q == '0) ? idx_q : first_q;
        state_d      = idx_q == IDX_W'(N_VECTORS - 1) ? DONE : SETTLE;
        idx_d        = idx_q == IDX_W'(N_VECTORS - 1) ? idx_q : idx_q + IDX_W'(1);
        cnt_d        = '0;
        pass_d       = idx_q == IDX_W'(N_VECTORS - 1) ? (!miss && err_q == '0) : pass_q;
      end
      default: begin
        // The edge leaving DONE is the earliest accepted start, so a held start chains sweeps.
        state_d = i_START ? SETTLE : IDLE;
        if (i_START) begin
          exp_d   = i_EXPECTED;
          idx_d   = '0;
          cnt_d   = '0;
          tbl_d   = '0;
          err_d   = '0;
          first_d = '0;
          pass_d  = 1'b0;
        end
      end
    endcase
  end
  always_ff @(posedge i_CLK) begin
    if (!i_RST_N) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      first_q <= '0;
      exp_q   <= '0;
      tbl_q   <= '0;
      err_q   <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
      exp_q   <= exp_d;
      tbl_q   <= tbl_d;
      err_q   <= err_d;
      pass_q  <= pass_d;
    end
  end
  assign o_BUSY                 = state_q == SETTLE || state_q == SAMPLE;
  assign o_DONE                 = state_q == DONE;
  assign {o_A, o_B, o_C, o_D}   = o_BUSY ? idx_q : '0;
  assign o_PASS                 = pass_q;
  assign o_TABLE                = tbl_q;
  assign o_ERR_COUNT            = err_q;
  assign o_FIRST_ERR_IDX        = first_q;
endmodule

// File: tb/tb_gate_sweep_checker.sv
// tb_gate_sweep_checker: scoreboard bench driving two checkers (settle 2 and settle 1) with gate models.
module tb_gate_sweep_checker;
  typedef struct {
    logic [15:0] tbl;
    int          err;
    int          first;
    logic        pass;
    int          ks;
  } exp_t;
  logic        clk = 1'b0;
  int          cyc = 0;
  int          checks = 0, fails = 0;
  logic        rst_n[2], start[2], y[2], a[2], b[2], c[2], dd[2], busy[2], done[2], pass[2];
  logic        glitch[2], quiet[2];
  logic [15:0] expv[2], tbl[2], gtbl[2];
  logic [4:0]  errc[2];
  logic [3:0]  fidx[2];
  int          cur_ks[2];
  exp_t        sbq[2][$];
  int          mon_s, mon_m;
  bit          mon_act;
  exp_t        mon_e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar j = 0; j < 2; j++) begin : g_dut
    gate_sweep_checker #(.SETTLE_CYCLES(j == 0 ? 2 : 1)) dut (
      .i_CLK(clk), .i_RST_N(rst_n[j]), .i_START(start[j]), .i_EXPECTED(expv[j]),
      .o_A(a[j]), .o_B(b[j]), .o_C(c[j]), .o_D(dd[j]), .i_Y(y[j]),
      .o_BUSY(busy[j]), .o_DONE(done[j]), .o_PASS(pass[j]), .o_TABLE(tbl[j]),
      .o_ERR_COUNT(errc[j]), .o_FIRST_ERR_IDX(fidx[j])
    );
    // Gate model; optional toggling outside the sample cycle must not affect results.
    assign y[j] = gtbl[j][{a[j], b[j], c[j], dd[j]}] ^
                  (glitch[j] && ((cyc - cur_ks[j]) % (j == 0 ? 3 : 2)) != (j == 0 ? 2 : 1) && cyc[0]);
  end

  function automatic int s_of(input int d);
    return d == 0 ? 2 : 1;
  endfunction

  function automatic exp_t model(input logic [15:0] g, input logic [15:0] e, input int ks);
    exp_t r;
    logic [15:0] x;
    x = g ^ e;
    r.tbl = g;
    r.err = $countones(x);
    r.first = 0;
    for (int i = 15; i >= 0; i--) if (x[i]) r.first = i;
    r.pass = r.err == 0;
    r.ks = ks;
    return r;
  endfunction

  task automatic chk(input string nm, input int d, input int act, input int req);
    checks++;
    if (act != req) begin
      fails++;
      $display("FAIL %s[%0d] actual=%0h required=%0h at cyc %0d", nm, d, act, req, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input int d, input logic [15:0] g, input logic [15:0] e, input logic gl);
    gtbl[d] = g;
    expv[d] = e;
    glitch[d] = gl;
    start[d] = 1'b1;
    tick();
    start[d] = 1'b0;
    cur_ks[d] = cyc;
    sbq[d].push_back(model(g, e, cyc));
  endtask

  task automatic wait_idle(input int d);
    int n = 0;
    while (sbq[d].size() != 0 && n < 400) begin
      tick();
      n++;
    end
    chk("timeout_pending", d, sbq[d].size(), 0);
    sbq[d].delete();
  endtask

  task automatic chk_zero(input int d);
    chk("rst_busy", d, busy[d], 0);
    chk("rst_done", d, done[d], 0);
    chk("rst_pass", d, pass[d], 0);
    chk("rst_table", d, tbl[d], 0);
    chk("rst_errc", d, errc[d], 0);
    chk("rst_fidx", d, fidx[d], 0);
    chk("rst_stim", d, {a[d], b[d], c[d], dd[d]}, 0);
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!quiet[d]) begin
        mon_s   = s_of(d);
        mon_act = sbq[d].size() > 0 && (cyc - sbq[d][0].ks) < 16 * (mon_s + 1);
        mon_m   = mon_act ? (cyc - sbq[d][0].ks) / (mon_s + 1) : 0;
        chk("busy", d, busy[d], int'(mon_act));
        chk("stim", d, {a[d], b[d], c[d], dd[d]}, mon_m);
        if (done[d]) begin
          if (sbq[d].size() == 0) chk("done_unexpected", d, done[d], 0);
          else begin
            mon_e = sbq[d].pop_front();
            chk("done_time", d, cyc - mon_e.ks, 16 * (mon_s + 1));
            chk("table", d, tbl[d], mon_e.tbl);
            chk("err_count", d, errc[d], mon_e.err);
            chk("first_err", d, fidx[d], mon_e.first);
            chk("pass", d, pass[d], mon_e.pass);
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] g, e, par;
    int seen, ks1;
    for (int d = 0; d < 2; d++) begin
      quiet[d] = 1'b1; rst_n[d] = 1'b0; start[d] = 1'b0; expv[d] = '0;
      gtbl[d] = '0; glitch[d] = 1'b0; cur_ks[d] = 0;
    end
    repeat (3) tick();
    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b1;
      chk_zero(d);
      quiet[d] = 1'b0;
    end
    // AND gate, matching expectation
    launch(0, 16'h8000, 16'h8000, 1'b0);
    wait_idle(0);
    // stuck-at-1 output against an OR expectation
    launch(0, 16'hFFFF, 16'hFFFE, 1'b0);
    wait_idle(0);
    // 4-input parity against all-zero expectation on the settle-1 instance
    for (int n = 0; n < 16; n++) par[n] = ^(4'(n));
    launch(1, par, 16'h0000, 1'b0);
    wait_idle(1);
    repeat (3) tick();
    chk("hold_table", 1, tbl[1], par);
    chk("hold_errc", 1, errc[1], 8);
    // start and expected change while busy are ignored
    g = 16'($urandom); e = 16'($urandom);
    launch(0, g, e, 1'b0);
    repeat (9) tick();
    start[0] = 1'b1; expv[0] = ~e;
    tick();
    start[0] = 1'b0;
    wait_idle(0);
    // reset at vector 7 aborts the sweep
    launch(0, 16'($urandom), 16'($urandom), 1'b0);
    repeat (21) tick();
    quiet[0] = 1'b1; rst_n[0] = 1'b0;
    tick();
    rst_n[0] = 1'b1;
    sbq[0].delete();
    chk_zero(0);
    quiet[0] = 1'b0;
    seen = 0;
    repeat (60) begin
      tick();
      seen |= int'(done[0]);
    end
    chk("no_done_after_reset", 0, seen, 0);
    launch(0, 16'($urandom), 16'($urandom), 1'b1);
    wait_idle(0);
    // start held high across two sweeps
    gtbl[1] = 16'h1234; expv[1] = 16'h0000; start[1] = 1'b1;
    tick();
    ks1 = cyc; cur_ks[1] = cyc;
    sbq[1].push_back(model(16'h1234, 16'h0000, ks1));
    repeat (32) tick();
    gtbl[1] = 16'hA5A5; expv[1] = 16'hA5A5;
    tick();
    chk("chain_start_edge", 1, cyc - ks1, 33);
    cur_ks[1] = cyc;
    sbq[1].push_back(model(16'hA5A5, 16'hA5A5, cyc));
    chk("chain_clr_table", 1, tbl[1], 0);
    chk("chain_clr_errc", 1, errc[1], 0);
    chk("chain_clr_fidx", 1, fidx[1], 0);
    chk("chain_clr_pass", 1, pass[1], 0);
    start[1] = 1'b0;
    wait_idle(1);
    // randomized sweeps on both instances concurrently, with settle-phase glitches
    fork
      for (int k = 0; k < 6; k++) begin
        g = 16'($urandom);
        launch(0, g, ($urandom_range(0, 2) == 0) ? g : g ^ 16'($urandom & $urandom), 1'b1);
        wait_idle(0);
      end
      for (int k = 0; k < 6; k++) begin
        logic [15:0] g1;
        g1 = 16'($urandom);
        launch(1, g1, ($urandom_range(0, 2) == 0) ? g1 : g1 ^ 16'($urandom & $urandom), 1'b1);
        wait_idle(1);
      end
    join
    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
